// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: latches a MEM-stage request, waits LATENCY cycles, then reads/writes a word RAM.
// Optional misaligned-access detection is enabled with `define DMEM_ALIGN_CHECK_EN.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_err
);

  localparam int DATA_W = 32;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic req, accept, fire, stall_raw, exec_ok;

  // Latched request; data side carries no reset
  logic                  wr_p0;
  logic [ADDR_WIDTH-1:0] word_p0;
  logic [DATA_W-1:0]     wdata_p0;
  logic [1:0]            off_p0;

  logic [DATA_W-1:0] ram [2**ADDR_WIDTH];

  function automatic logic is_misaligned(input logic [1:0] off);
    return off != 2'b00;
  endfunction

  assign req = mem_ren | mem_wen;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_raw = 1'b0;
    accept    = 1'b0;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          stall_raw = 1'b1;
          accept    = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        stall_raw = 1'b1;
        if (cnt == 4'd0) begin
          fire      = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reset must drop the stall immediately even while a request is held
  assign mem_stall = stall_raw & ~rst;

  // p0 boundary: request capture in IDLE
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      wr_p0    <= mem_wen;
      word_p0  <= mem_addr[ADDR_WIDTH+1:2];
      wdata_p0 <= mem_dout;
      off_p0   <= mem_addr[1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Access boundary: WAIT->DONE edge performs the RAM operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_din <= '0;
    end else if (fire && !wr_p0 && exec_ok) begin
      mem_din <= ram[word_p0];
    end
  end

  always_ff @(posedge clk) begin
    if (fire && wr_p0 && exec_ok && !rst) begin
      ram[word_p0] <= wdata_p0;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[31:ADDR_WIDTH+2];
  assign exec_ok = !is_misaligned(off_p0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_err <= 1'b0;
    end else if (accept) begin
      mem_err <= 1'b0;
    end else if (fire) begin
      mem_err <= is_misaligned(off_p0);
    end
  end
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:ADDR_WIDTH+2], is_misaligned(off_p0)};
  assign exec_ok = 1'b1;
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (LATENCY=2, ADDR_WIDTH=10).
module tb_data_mem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_dout;
  logic [31:0] mem_din;
  logic        mem_stall, mem_err;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .mem_stall (mem_stall),
    .mem_err   (mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge with the DUT in IDLE.
  task automatic access(input string tag, input logic ren, input logic wen,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_din, input logic exp_err);
    mem_ren  = ren;
    mem_wen  = wen;
    mem_addr = addr;
    mem_dout = wdata;
    @(negedge clk);
    chk({tag, ".stall_idle"}, 32'(mem_stall), 32'd1);
    @(posedge clk); #1;
    mem_ren  = 1'b0;
    mem_wen  = 1'b0;
    mem_addr = 32'hFFFF_FFFF;
    mem_dout = 32'h0BAD_0BAD;
    @(negedge clk);
    chk({tag, ".stall_wait1"}, 32'(mem_stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".stall_wait2"}, 32'(mem_stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".stall_done"}, 32'(mem_stall), 32'd0);
    chk({tag, ".din"}, mem_din, exp_din);
    chk({tag, ".err"}, 32'(mem_err), 32'(exp_err));
    @(posedge clk); #1;
  endtask

  initial begin
    rst      = 1'b1;
    mem_ren  = 1'b0;
    mem_wen  = 1'b0;
    mem_addr = '0;
    mem_dout = '0;
    repeat (2) @(posedge clk);
    #1;
    mem_ren = 1'b1;
    #1;
    chk("reset.stall", 32'(mem_stall), 32'd0);
    chk("reset.din", mem_din, 32'd0);
    chk("reset.err", 32'(mem_err), 32'd0);
    mem_ren = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Write then read back, first request right after reset release
    access("wr10", 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
    access("rd10", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
    access("rd1010_alias", 1'b1, 1'b0, 32'h0000_1010, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Both strobes high behaves as a write; mem_din must hold
    access("both20", 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0);
    access("rd20", 1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h1234_5678, 1'b0);

    // Back-to-back reads of 0x10 and 0x14
    access("wr14", 1'b0, 1'b1, 32'h0000_0014, 32'hA5A5_0014, 32'h1234_5678, 1'b0);
    access("b2b_rd10", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
    access("b2b_rd14", 1'b1, 1'b0, 32'h0000_0014, 32'h0, 32'hA5A5_0014, 1'b0);

    // Reset during the second WAIT cycle aborts the pending write
    access("wr30", 1'b0, 1'b1, 32'h0000_0030, 32'h1111_1111, 32'hA5A5_0014, 1'b0);
    mem_wen  = 1'b1;
    mem_addr = 32'h0000_0030;
    mem_dout = 32'h55AA_55AA;
    @(posedge clk); #1;
    mem_wen = 1'b0;
    @(posedge clk); #1;
    chk("abort.stall_pre", 32'(mem_stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort.stall", 32'(mem_stall), 32'd0);
    chk("abort.din", mem_din, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort.idle_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    access("rd30", 1'b1, 1'b0, 32'h0000_0030, 32'h0, 32'h1111_1111, 1'b0);

    // Misaligned write to 0x41 targets word 0x10
    access("wr40", 1'b0, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 32'h1111_1111, 1'b0);
    access("wr41", 1'b0, 1'b1, 32'h0000_0041, 32'h0000_0033, 32'h1111_1111, ALIGN_EN);
    access("rd40", 1'b1, 1'b0, 32'h0000_0040, 32'h0,
           ALIGN_EN ? 32'hCAFE_F00D : 32'h0000_0033, 1'b0);
    // Misaligned read: suppressed update with the check, normal read without
    access("rd42", 1'b1, 1'b0, 32'h0000_0042, 32'h0,
           ALIGN_EN ? 32'hCAFE_F00D : 32'h0000_0033, ALIGN_EN);
    access("rd20_again", 1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h1234_5678, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
